// File: rtl/sprite_mem_pkg.sv
// Shared constants and FSM encoding for the sprite RAM arbiter.
// Holds the RAM widths, the default access time and the state type.
package sprite_mem_pkg;
  localparam int ADDR_W            = 26;
  localparam int DATA_W            = 16;
  localparam int ACCESS_CYCLES_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;
endpackage

// File: rtl/sprite_mem_arbiter_rr_picker.sv
// Round-robin picker: first set req bit at or after ptr, wrapping mod N.
// Ports: req/ptr in; found flag and winner index out. Purely combinational.
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic         found,
  output logic [2:0]   win
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = 3'd0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
  end
endmodule

// File: rtl/sprite_mem_arbiter.sv
// Round-robin arbiter sharing one cellular-RAM read port among requesters.
// Ports: clk, rst(active-low sync), req/addr_flat in; ack/rdata/busy/gnt_id out; mem_addr/mem_data to RAM.
module sprite_mem_arbiter
  import sprite_mem_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_W        = sprite_mem_pkg::ADDR_W,
  parameter int DATA_W        = sprite_mem_pkg::DATA_W,
  parameter int ACCESS_CYCLES = sprite_mem_pkg::ACCESS_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_flat,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [2:0]                gnt_id,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_data
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [2:0]          gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  gnt_mask, pick_req;
  logic [2:0]          nxt_ptr, pick_ptr, win;
  logic                found;

  assign nxt_ptr  = (gnt_q >= 3'(NUM_REQ-1)) ? 3'd0 : gnt_q + 3'd1;
  assign gnt_mask = NUM_REQ'(1) << gnt_q;

  // In CAPTURE the finishing grantee still holds req until it sees ack;
  // hide it so it is not re-granted for the word it is about to receive.
  assign pick_req = (state_q == CAPTURE) ? (req & ~gnt_mask) : req;
  assign pick_ptr = (state_q == CAPTURE) ? nxt_ptr : ptr_q;

  rr_picker #(.N(NUM_REQ)) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .found (found),
    .win   (win)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    busy_d  = busy_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (found) begin
          state_d = ACCESS;
          gnt_d   = win;
          addr_d  = addr_flat[int'(win)*ADDR_W +: ADDR_W];
          cnt_d   = CW'(ACCESS_CYCLES-1);
          busy_d  = 1'b1;
        end
      end
      (state_q == ACCESS): begin
        if (cnt_q == '0) state_d = CAPTURE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      (state_q == CAPTURE): begin
        rdata_d = mem_data;
        ptr_d   = nxt_ptr;
        if (req[gnt_q[IW-1:0]]) ack_d[gnt_q[IW-1:0]] = 1'b1;
        if (found) begin
          state_d = ACCESS;
          gnt_d   = win;
          addr_d  = addr_flat[int'(win)*ADDR_W +: ADDR_W];
          cnt_d   = CW'(ACCESS_CYCLES-1);
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 3'd0;
      gnt_q   <= 3'd0;
      addr_q  <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign gnt_id   = gnt_q;
  assign mem_addr = addr_q;
endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Directed bench for sprite_mem_arbiter (4 req x 8 cycles, 3 req x 1 cycle).
// RAM model returns addr[15:0]^16'h5A5A unless a fixed word is forced.
module tb_sprite_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [103:0] addr_flat;
  logic [3:0]   ack;
  logic [15:0]  rdata, mem_data, mem_fixed;
  logic         busy, use_fixed;
  logic [2:0]   gnt_id;
  logic [25:0]  mem_addr;

  logic [2:0]   req3;
  logic [77:0]  addr3;
  logic [2:0]   ack3;
  logic [15:0]  rdata3, mdata3;
  logic         busy3;
  logic [2:0]   gnt3;
  logic [25:0]  maddr3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  assign mem_data = use_fixed ? mem_fixed : (mem_addr[15:0] ^ 16'h5A5A);
  assign mdata3   = maddr3[15:0] ^ 16'h5A5A;

  always #5 clk = ~clk;

  sprite_mem_arbiter #(.NUM_REQ(4), .ACCESS_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req(req), .addr_flat(addr_flat),
    .ack(ack), .rdata(rdata), .busy(busy), .gnt_id(gnt_id),
    .mem_addr(mem_addr), .mem_data(mem_data)
  );

  sprite_mem_arbiter #(.NUM_REQ(3), .ACCESS_CYCLES(1)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .addr_flat(addr3),
    .ack(ack3), .rdata(rdata3), .busy(busy3), .gnt_id(gnt3),
    .mem_addr(maddr3), .mem_data(mdata3)
  );

  function automatic logic [25:0] a4(input int i);
    return 26'h100 * 26'(i + 1);
  endfunction

  function automatic logic [25:0] a3(input int i);
    return 26'h20000 + 26'h11 * 26'(i);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_addrs;
    for (int i = 0; i < 4; i++) addr_flat[i*26 +: 26] = a4(i);
    for (int i = 0; i < 3; i++) addr3[i*26 +: 26] = a3(i);
  endtask

  task automatic do_reset;
    rst = 1'b0; req = '0; req3 = '0;
    tick; tick;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; req = 4'b1111;
    tick; tick; tick;
    total++; if (ack !== 4'b0) begin bad++; $display("FAIL reset_ack got=%h want=0", ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (mem_addr !== 26'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", mem_addr); end
    total++; if (rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
    total++; if (gnt_id !== 3'd0) begin bad++; $display("FAIL reset_gnt got=%0d want=0", gnt_id); end
    rst = 1'b1;
    tick;
    total++; if (busy !== 1'b1 || gnt_id !== 3'd0) begin bad++; $display("FAIL release_grant got=%b/%0d want=1/0", busy, gnt_id); end
    total++; if (mem_addr !== a4(0)) begin bad++; $display("FAIL release_addr got=%h want=%h", mem_addr, a4(0)); end
    do_reset;
  endtask

  task automatic test_single;
    use_fixed = 1'b1; mem_fixed = 16'hBEEF;
    addr_flat[26 +: 26] = 26'h0001234;
    req = 4'b0010;
    tick;
    total++; if (busy !== 1'b1 || gnt_id !== 3'd1) begin bad++; $display("FAIL single_grant got=%b/%0d want=1/1", busy, gnt_id); end
    addr_flat[26 +: 26] = 26'h3FFFFFF;
    for (int k = 1; k <= 8; k++) begin
      tick;
      total++;
      if (ack !== 4'b0 || mem_addr !== 26'h0001234) begin
        bad++; $display("FAIL single_hold k=%0d ack=%h addr=%h want 0/0001234", k, ack, mem_addr);
      end
    end
    tick;
    total++; if (ack !== 4'b0010) begin bad++; $display("FAIL single_ack got=%h want=2", ack); end
    total++; if (rdata !== 16'hBEEF) begin bad++; $display("FAIL single_rdata got=%h want=beef", rdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", busy); end
    req = 4'b0;
    tick;
    total++; if (ack !== 4'b0) begin bad++; $display("FAIL single_ack_pulse got=%h want=0", ack); end
    use_fixed = 1'b0;
    set_addrs;
  endtask

  task automatic test_back_to_back;
    int start, prev, waited, exp;
    do_reset;
    req = 4'b1111;
    start = cyc; prev = cyc;
    for (int n = 0; n < 5; n++) begin
      exp = n % 4;
      waited = 0;
      do begin tick; waited++; end while (ack === 4'b0 && waited < 20);
      total++;
      if (ack !== (4'b1 << exp)) begin
        bad++; $display("FAIL b2b_order n=%0d got=%h want=%h", n, ack, 4'b1 << exp);
      end
      total++;
      if (rdata !== (a4(exp)[15:0] ^ 16'h5A5A)) begin
        bad++; $display("FAIL b2b_rdata n=%0d got=%h want=%h", n, rdata, a4(exp)[15:0] ^ 16'h5A5A);
      end
      total++;
      if ((n == 0 && cyc - start != 10) || (n != 0 && cyc - prev != 9)) begin
        bad++; $display("FAIL b2b_spacing n=%0d got=%0d want=%0d", n, (n == 0) ? cyc - start : cyc - prev, (n == 0) ? 10 : 9);
      end
      prev = cyc;
    end
    req = 4'b0;
    do_reset;
  endtask

  task automatic test_withdraw;
    do_reset;
    req = 4'b0011;
    tick; tick; tick; tick;
    req = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      tick;
      total++; if (ack !== 4'b0) begin bad++; $display("FAIL wd_quiet k=%0d got=%h want=0", k, ack); end
    end
    tick;
    total++; if (ack !== 4'b0) begin bad++; $display("FAIL wd_noack got=%h want=0", ack); end
    total++; if (rdata !== (a4(0)[15:0] ^ 16'h5A5A)) begin bad++; $display("FAIL wd_rdata got=%h want=%h", rdata, a4(0)[15:0] ^ 16'h5A5A); end
    total++; if (gnt_id !== 3'd1 || busy !== 1'b1) begin bad++; $display("FAIL wd_next got=%0d/%b want=1/1", gnt_id, busy); end
    for (int k = 0; k < 8; k++) tick;
    tick;
    total++; if (ack !== 4'b0010) begin bad++; $display("FAIL wd_ack1 got=%h want=2", ack); end
    req = 4'b0;
    do_reset;
  endtask

  task automatic test_reset_mid;
    do_reset;
    req = 4'b0110;
    tick; tick; tick;
    rst = 1'b0;
    tick;
    total++; if (busy !== 1'b0 || ack !== 4'b0 || gnt_id !== 3'd0) begin
      bad++; $display("FAIL mid_reset got=%b/%h/%0d want=0/0/0", busy, ack, gnt_id);
    end
    rst = 1'b1;
    tick;
    total++; if (gnt_id !== 3'd1 || busy !== 1'b1) begin bad++; $display("FAIL mid_regrant got=%0d/%b want=1/1", gnt_id, busy); end
    for (int k = 0; k < 8; k++) begin
      tick;
      total++; if (ack !== 4'b0) begin bad++; $display("FAIL mid_phantom k=%0d got=%h want=0", k, ack); end
    end
    tick;
    total++; if (ack !== 4'b0010) begin bad++; $display("FAIL mid_ack got=%h want=2", ack); end
    req = 4'b0;
    do_reset;
  endtask

  task automatic test_small;
    do_reset;
    req3 = 3'b101;
    tick;
    total++; if (gnt3 !== 3'd0 || busy3 !== 1'b1) begin bad++; $display("FAIL sm_grant got=%0d/%b want=0/1", gnt3, busy3); end
    tick;
    total++; if (ack3 !== 3'b000) begin bad++; $display("FAIL sm_e2 got=%b want=000", ack3); end
    tick;
    total++; if (ack3 !== 3'b001) begin bad++; $display("FAIL sm_ack0 got=%b want=001", ack3); end
    total++; if (rdata3 !== (a3(0)[15:0] ^ 16'h5A5A)) begin bad++; $display("FAIL sm_rd0 got=%h want=%h", rdata3, a3(0)[15:0] ^ 16'h5A5A); end
    tick;
    total++; if (ack3 !== 3'b000) begin bad++; $display("FAIL sm_e4 got=%b want=000", ack3); end
    tick;
    total++; if (ack3 !== 3'b100) begin bad++; $display("FAIL sm_ack2 got=%b want=100", ack3); end
    total++; if (rdata3 !== (a3(2)[15:0] ^ 16'h5A5A)) begin bad++; $display("FAIL sm_rd2 got=%h want=%h", rdata3, a3(2)[15:0] ^ 16'h5A5A); end
    tick;
    tick;
    total++; if (ack3 !== 3'b001) begin bad++; $display("FAIL sm_wrap got=%b want=001", ack3); end
    total++; if (gnt3 !== 3'd2) begin bad++; $display("FAIL sm_gnt got=%0d want=2", gnt3); end
    req3 = 3'b0;
    do_reset;
  endtask

  initial begin
    rst = 1'b0; req = '0; req3 = '0;
    use_fixed = 1'b0; mem_fixed = 16'h0;
    set_addrs;
    test_reset;
    test_single;
    test_back_to_back;
    test_withdraw;
    test_reset_mid;
    test_small;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sprite_mem_arbiter.md
Name: sprite_mem_arbiter

Overview:
Shares the single cellular-RAM read port between up to NUM_REQ pixel/sprite fetch requesters (background, player, enemy, boss/overlay). Each requester gets a round-robin grant, the RAM address is sequenced for a fixed access time, and the returned 16-bit word is routed back with a one-cycle ack. Sits between the sprite controllers and cellular_ram_controller, replacing the direct single-address hookup so the background address path can be used.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 26, RAM word address width
DATA_W, 16, RAM data width
ACCESS_CYCLES, 8, clk cycles the address is held before data is sampled (min 1; 8 = 80 ns at 100 MHz)

Ports:
clk  in  1  100 MHz system clock
rst  in  1  synchronous reset, active-low
req  in  NUM_REQ  per-requester read request; held high with addr stable until ack
addr_flat  in  NUM_REQ*ADDR_W  requester addresses; requester i at [i*ADDR_W +: ADDR_W]
ack  out  NUM_REQ  one-cycle pulse: rdata valid for that requester
rdata  out  DATA_W  captured RAM word, broadcast to all requesters
busy  out  1  high while an access is in flight
gnt_id  out  3  index of current/last grantee
mem_addr  out  ADDR_W  address to cellular_ram_controller
mem_data  in  DATA_W  MemDB from RAM

Behaviour:
- Reset (rst=0 at posedge clk): state IDLE, ack=0, rdata=0, busy=0, gnt_id=0, mem_addr=0, rr pointer=0, counter=0. Reset mid-access aborts it; no ack is issued for the aborted access.
- FSM states: IDLE, ACCESS, CAPTURE.
- IDLE: if any req bit is set, pick the first set bit at or after the rr pointer (wrapping modulo NUM_REQ). Latch gnt_id, drive mem_addr from that requester's slice, set busy=1, counter=ACCESS_CYCLES-1, go to ACCESS. If no req bit is set, stay in IDLE; mem_addr holds its last value.
- ACCESS: counter decrements each cycle. When counter==0, go to CAPTURE. mem_addr is frozen during ACCESS even if the requester changes its addr.
- CAPTURE (1 cycle): rdata<=mem_data. If req[gnt_id] is still 1, ack[gnt_id]<=1 on the next cycle; otherwise the data is discarded and no ack is issued. rr pointer<=(gnt_id+1) mod NUM_REQ. If any request is pending, arbitrate in this same cycle and enter ACCESS directly, giving back-to-back accesses with no IDLE bubble. Otherwise go to IDLE and set busy=0.
- Latency: a request seen in IDLE at cycle T gets ack at T+ACCESS_CYCLES+2. Sustained throughput is one word per ACCESS_CYCLES+1 cycles.
- ack is at most one-hot and lasts exactly one cycle. rdata holds its value until the next CAPTURE.
- A requester must drop req or present a new addr in the cycle after ack. If req is still high after ack, it is treated as a new request.
- Simultaneous requests: strict round robin. Worst-case wait is NUM_REQ*(ACCESS_CYCLES+1) cycles. No starvation.
- A request that rises during another requester's access is not lost; it is considered at the next arbitration point.
- gnt_id and rr pointer arithmetic wraps modulo NUM_REQ, including non-power-of-2 values.

Decomposition:
- Package sprite_mem_pkg: ADDR_W, DATA_W, state encoding (IDLE=2'd0, ACCESS=2'd1, CAPTURE=2'd2), and a default ACCESS_CYCLES constant.
- Sub-module rr_picker: combinational. Inputs req vector and pointer; outputs found flag and winner index. It is instantiated once and reused from both IDLE and CAPTURE.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req=4'b1111 -> ack=0, busy=0, mem_addr=0, rdata=0; arbitration starts on the first cycle after rst=1.
- Single request: req=4'b0010, addr1=26'h000_1234, mem_data=16'hBEEF -> mem_addr=26'h0001234 for 8 cycles, then ack=4'b0010 at T+10 with rdata=16'hBEEF.
- Contention: req=4'b1111 held, pointer=0 -> grant order 0,1,2,3,0 with acks spaced exactly 9 cycles apart and no IDLE bubble.
- Withdrawal: req0 dropped during ACCESS cycle 4 -> no ack0; rdata updated; next grant goes to requester 1 if it is pending.
- Reset mid-access: rst=0 at ACCESS cycle 3 -> no ack ever for that access; after release, the same request re-arbitrates from pointer 0.
- ACCESS_CYCLES=1, NUM_REQ=3 with req=3'b101 -> acks alternate 0,2,0 every 2 cycles; the pointer wraps from 2 to 0.
